mem_access_unit: RTL and testbench

//  Parametrised load/store unit for the MIPS150 memory stage. It generalises the single-cycle,

---
 rtl/mem_access_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Load/store unit for the MIPS150 memory stage. Accepts one load or store
//   from the pipeline, derives byte enables and lane-positioned store data,
//   drives a valid/ready memory request, waits for the read response of a
//   load and returns the extracted, sign/zero-extended result. Misaligned or
//   illegal ops are trapped and never reach memory.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   op_valid/op_ready   pipeline handshake (op_ready high only when idle)
//   op_store/op_size/op_signed/op_addr/op_wdata/op_tag   op description
//   mem_req_*           memory request (addr aligned to the word, be, wdata, io)
//   mem_rsp_valid/rdata read response, only looked at while awaiting it
//   done                one-cycle retire pulse for every op
//   ld_valid/ld_data/ld_tag   load result, data and tag held until next load
//   misalign            one-cycle pulse with done for a trapped op
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int         DATA_W     = 32,
    parameter int         ADDR_W     = 32,
    parameter int         TAG_W      = 5,
    parameter int         BIG_ENDIAN = 1,
    parameter logic [3:0] IO_REGION  = 4'h8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic                op_store,
    input  logic [1:0]          op_size,
    input  logic                op_signed,
    input  logic [ADDR_W-1:0]   op_addr,
    input  logic [DATA_W-1:0]   op_wdata,
    input  logic [TAG_W-1:0]    op_tag,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W/8-1:0] mem_req_be,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic                mem_req_io,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata,
    output logic                done,
    output logic                ld_valid,
    output logic [DATA_W-1:0]   ld_data,
    output logic [TAG_W-1:0]    ld_tag,
    output logic                misalign
);

    localparam int         NB    = DATA_W / 8;
    localparam int         OFF_W = $clog2(NB);
    localparam logic [3:0] NB_L  = 4'(NB);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    logic [1:0]        state_r;
    logic              op_ready_r;
    logic              store_r;
    logic [1:0]        size_r;
    logic              signed_r;
    logic [TAG_W-1:0]  tag_r;
    logic [3:0]        sh_r;
    logic              req_valid_r;
    logic [ADDR_W-1:0] req_addr_r;
    logic [NB-1:0]     req_be_r;
    logic [DATA_W-1:0] req_wdata_r;
    logic              req_io_r;
    logic              done_r;
    logic              ld_valid_r;
    logic [DATA_W-1:0] ld_data_r;
    logic [TAG_W-1:0]  ld_tag_r;
    logic              misalign_r;

    logic [3:0]        nb_s;
    logic [3:0]        off_s;
    logic [3:0]        sh_s;
    logic              trap_s;
    logic [NB-1:0]     be_s;
    logic [DATA_W-1:0] dmask_s;
    logic [DATA_W-1:0] wdata_s;
    logic [ADDR_W-1:0] addr_aligned_s;
    logic              io_s;

    logic [3:0]        nb_r_s;
    logic [DATA_W-1:0] shifted_s;
    logic              sign_s;
    logic              fill_s;
    logic [DATA_W-1:0] ext_s;

    // Decode the offered op: access width, lane shift, trap, enables and data.
    // The lane shift is the lowest lane touched: the byte offset for little
    // endian, and NB - offset - size for big endian (first byte in top lane).
    always_comb begin
        nb_s  = 4'd1 << op_size;
        off_s = 4'(op_addr[OFF_W-1:0]);
        if (BIG_ENDIAN != 0) begin
            sh_s = NB_L - off_s - nb_s;
        end else begin
            sh_s = off_s;
        end
        case (op_size)
            2'd0:    trap_s = 1'b0;
            2'd1:    trap_s = op_addr[0];
            2'd2:    trap_s = |op_addr[1:0];
            default: trap_s = (DATA_W == 32) ? 1'b1 : (|op_addr[2:0]);
        endcase
        for (int k = 0; k < NB; k++) begin
            be_s[k]             = (4'(k) >= sh_s) && (4'(k) < (sh_s + nb_s));
            dmask_s[k*8 +: 8]   = (4'(k) < nb_s) ? 8'hFF : 8'h00;
        end
        wdata_s                     = (op_wdata & dmask_s) << {sh_s, 3'b000};
        addr_aligned_s              = op_addr;
        addr_aligned_s[OFF_W-1:0]   = {OFF_W{1'b0}};
        io_s                        = (op_addr[ADDR_W-1 -: 4] == IO_REGION);
    end

    // Extract the addressed bytes of the read word and extend them.
    always_comb begin
        nb_r_s    = 4'd1 << size_r;
        shifted_s = mem_rsp_rdata >> {sh_r, 3'b000};
        case (size_r)
            2'd0:    sign_s = shifted_s[7];
            2'd1:    sign_s = shifted_s[15];
            2'd2:    sign_s = shifted_s[31];
            default: sign_s = 1'b0;
        endcase
        fill_s = signed_r & sign_s;
        for (int k = 0; k < NB; k++) begin
            ext_s[k*8 +: 8] = (4'(k) < nb_r_s) ? shifted_s[k*8 +: 8] : {8{fill_s}};
        end
    end

    // Control FSM with registered request, retire pulses and load result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            op_ready_r  <= 1'b1;
            store_r     <= 1'b0;
            size_r      <= 2'd0;
            signed_r    <= 1'b0;
            tag_r       <= {TAG_W{1'b0}};
            sh_r        <= 4'd0;
            req_valid_r <= 1'b0;
            req_addr_r  <= {ADDR_W{1'b0}};
            req_be_r    <= {NB{1'b0}};
            req_wdata_r <= {DATA_W{1'b0}};
            req_io_r    <= 1'b0;
            done_r      <= 1'b0;
            ld_valid_r  <= 1'b0;
            ld_data_r   <= {DATA_W{1'b0}};
            ld_tag_r    <= {TAG_W{1'b0}};
            misalign_r  <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            ld_valid_r <= 1'b0;
            misalign_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (op_valid && op_ready_r) begin
                        op_ready_r <= 1'b0;
                        store_r    <= op_store;
                        size_r     <= op_size;
                        signed_r   <= op_signed;
                        tag_r      <= op_tag;
                        sh_r       <= sh_s;
                        if (trap_s) begin
                            state_r    <= ST_FIN;
                            done_r     <= 1'b1;
                            misalign_r <= 1'b1;
                        end else begin
                            state_r     <= ST_REQ;
                            req_valid_r <= 1'b1;
                            req_addr_r  <= addr_aligned_s;
                            req_be_r    <= op_store ? be_s : {NB{1'b0}};
                            req_wdata_r <= op_store ? wdata_s : {DATA_W{1'b0}};
                            req_io_r    <= io_s;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        req_valid_r <= 1'b0;
                        if (store_r) begin
                            state_r <= ST_FIN;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RSP;
                        end
                    end
                end
                ST_RSP: begin
                    if (mem_rsp_valid) begin
                        state_r    <= ST_FIN;
                        done_r     <= 1'b1;
                        ld_valid_r <= 1'b1;
                        ld_data_r  <= ext_s;
                        ld_tag_r   <= tag_r;
                    end
                end
                ST_FIN: begin
                    state_r    <= ST_IDLE;
                    op_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    op_ready_r  <= 1'b1;
                    req_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign op_ready      = op_ready_r;
    assign mem_req_valid = req_valid_r;
    assign mem_req_addr  = req_addr_r;
    assign mem_req_be    = req_be_r;
    assign mem_req_wdata = req_wdata_r;
    assign mem_req_io    = req_io_r;
    assign done          = done_r;
    assign ld_valid      = ld_valid_r;
    assign ld_data       = ld_data_r;
    assign ld_tag        = ld_tag_r;
    assign misalign      = misalign_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//   Two instances: a 32-bit big-endian unit (a) and a 64-bit little-endian
//   unit (b). Ops are driven with directed and random fields; expectations
//   come from a byte-address model of memory lanes.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid_a, op_valid_b;
    logic        op_store;
    logic [1:0]  op_size;
    logic        op_signed;
    logic [31:0] op_addr;
    logic [63:0] op_wdata;
    logic [4:0]  op_tag;
    logic        mem_req_ready;
    logic        mem_rsp_valid_a, mem_rsp_valid_b;
    logic [63:0] mem_rsp_rdata;

    logic        a_op_ready, a_req_valid, a_req_io, a_done, a_ld_valid, a_misalign;
    logic [31:0] a_req_addr, a_req_wdata, a_ld_data;
    logic [3:0]  a_req_be;
    logic [4:0]  a_ld_tag;
    logic        b_op_ready, b_req_valid, b_req_io, b_done, b_ld_valid, b_misalign;
    logic [31:0] b_req_addr;
    logic [63:0] b_req_wdata, b_ld_data;
    logic [7:0]  b_req_be;
    logic [4:0]  b_ld_tag;

    logic        sel_r;
    logic        o_ready, o_valid, o_io, o_done, o_ldv, o_mis;
    logic [31:0] o_addr;
    logic [63:0] o_be, o_wdata, o_ld;
    logic [4:0]  o_tag;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] last_ld [2];
    logic [63:0] cap_be, cap_wd, cap_ld;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(32), .BIG_ENDIAN(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .op_valid(op_valid_a), .op_ready(a_op_ready), .op_store(op_store),
        .op_size(op_size), .op_signed(op_signed), .op_addr(op_addr),
        .op_wdata(op_wdata[31:0]), .op_tag(op_tag),
        .mem_req_valid(a_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(a_req_addr), .mem_req_be(a_req_be), .mem_req_wdata(a_req_wdata),
        .mem_req_io(a_req_io), .mem_rsp_valid(mem_rsp_valid_a),
        .mem_rsp_rdata(mem_rsp_rdata[31:0]),
        .done(a_done), .ld_valid(a_ld_valid), .ld_data(a_ld_data), .ld_tag(a_ld_tag),
        .misalign(a_misalign)
    );

    mem_access_unit #(.DATA_W(64), .BIG_ENDIAN(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .op_valid(op_valid_b), .op_ready(b_op_ready), .op_store(op_store),
        .op_size(op_size), .op_signed(op_signed), .op_addr(op_addr),
        .op_wdata(op_wdata), .op_tag(op_tag),
        .mem_req_valid(b_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(b_req_addr), .mem_req_be(b_req_be), .mem_req_wdata(b_req_wdata),
        .mem_req_io(b_req_io), .mem_rsp_valid(mem_rsp_valid_b),
        .mem_rsp_rdata(mem_rsp_rdata),
        .done(b_done), .ld_valid(b_ld_valid), .ld_data(b_ld_data), .ld_tag(b_ld_tag),
        .misalign(b_misalign)
    );

    // Present the selected instance's outputs on a common 64-bit view.
    always_comb begin
        if (sel_r) begin
            o_ready = b_op_ready; o_valid = b_req_valid; o_io = b_req_io;
            o_done = b_done; o_ldv = b_ld_valid; o_mis = b_misalign;
            o_addr = b_req_addr; o_be = {56'd0, b_req_be}; o_wdata = b_req_wdata;
            o_ld = b_ld_data; o_tag = b_ld_tag;
        end else begin
            o_ready = a_op_ready; o_valid = a_req_valid; o_io = a_req_io;
            o_done = a_done; o_ldv = a_ld_valid; o_mis = a_misalign;
            o_addr = a_req_addr; o_be = {60'd0, a_req_be}; o_wdata = {32'd0, a_req_wdata};
            o_ld = {32'd0, a_ld_data}; o_tag = a_ld_tag;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_valid(input bit sel, input bit v);
        op_valid_a = v && !sel;
        op_valid_b = v && sel;
    endtask

    task automatic set_rsp(input bit sel, input bit v);
        mem_rsp_valid_a = v && !sel;
        mem_rsp_valid_b = v && sel;
    endtask

    task automatic scramble();
        op_store  = 1'($urandom);
        op_size   = 2'($urandom);
        op_signed = 1'($urandom);
        op_addr   = $urandom;
        op_wdata  = {$urandom, $urandom};
        op_tag    = 5'($urandom);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ready"}, o_ready, 1'b1);
        check_eq({tag, "_valid"}, o_valid, 1'b0);
        check_eq({tag, "_done"}, o_done, 1'b0);
        check_eq({tag, "_ldv"}, o_ldv, 1'b0);
        check_eq({tag, "_mis"}, o_mis, 1'b0);
        check_eq({tag, "_ld"}, o_ld, 64'd0);
        check_eq({tag, "_ldtag"}, o_tag, 5'd0);
        check_eq({tag, "_be"}, o_be, 64'd0);
        check_eq({tag, "_addr"}, o_addr, 32'd0);
        check_eq({tag, "_wd"}, o_wdata, 64'd0);
        check_eq({tag, "_io"}, o_io, 1'b0);
    endtask

    // Drive one op through a unit and check every cycle against the model.
    task automatic run_op(input bit sel, input bit st, input logic [1:0] sz, input bit sg,
                          input logic [31:0] ad, input logic [63:0] wd, input logic [4:0] tg,
                          input logic [63:0] rd, input int waits, input int rdly, input bit abort);
        int dw, n, off, lane, vb, a;
        bit bend, trap, eio;
        logic [63:0] ebe, ewd, eld;
        logic [31:0] eaddr;

        // Model: memory word viewed as bytes at addresses 0..dw-1.
        dw    = sel ? 8 : 4;
        bend  = !sel;
        n     = 1 << sz;
        off   = int'(ad[2:0]) % dw;
        trap  = (sz == 2'd3 && dw == 4) || ((int'(ad[2:0]) % n) != 0);
        eaddr = ad & ~(32'(dw - 1));
        eio   = (ad[31:28] == 4'h8);
        ebe = 64'd0; ewd = 64'd0; eld = 64'd0;
        if (!trap) begin
            for (int i = 0; i < n; i++) begin
                a    = off + i;
                lane = bend ? (dw - 1 - a) : a;
                vb   = bend ? (n - 1 - i) : i;
                if (st) begin
                    ebe[lane] = 1'b1;
                    ewd[lane*8 +: 8] = wd[vb*8 +: 8];
                end else begin
                    eld[vb*8 +: 8] = rd[lane*8 +: 8];
                end
            end
            if (sg && n < 8 && eld[n*8-1]) begin
                for (int j = n; j < 8; j++) eld[j*8 +: 8] = 8'hFF;
            end
            if (dw == 4) eld[63:32] = 32'd0;
        end

        sel_r = sel;
        @(negedge clk);
        op_store = st; op_size = sz; op_signed = sg; op_addr = ad; op_wdata = wd; op_tag = tg;
        set_valid(sel, 1'b1);
        check_eq("op_ready_idle", o_ready, 1'b1);
        @(negedge clk);
        scramble();
        if (trap) begin
            check_eq("trap_done", o_done, 1'b1);
            check_eq("trap_mis", o_mis, 1'b1);
            check_eq("trap_ldv", o_ldv, 1'b0);
            check_eq("trap_noreq", o_valid, 1'b0);
            check_eq("trap_ldhold", o_ld, last_ld[sel]);
            set_valid(sel, 1'b0);
            return;
        end
        for (int w = 0; w <= waits; w++) begin
            check_eq("req_valid", o_valid, 1'b1);
            check_eq("req_addr", o_addr, eaddr);
            check_eq("req_be", o_be, ebe);
            check_eq("req_wdata", o_wdata, ewd);
            check_eq("req_io", o_io, eio);
            check_eq("req_busy", o_ready, 1'b0);
            check_eq("req_nodone", o_done, 1'b0);
            cap_be = o_be; cap_wd = o_wdata;
            mem_req_ready = (w == waits);
            set_rsp(sel, 1'($urandom));
            mem_rsp_rdata = {$urandom, $urandom};
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
        set_rsp(sel, 1'b0);
        if (st) begin
            check_eq("st_done", o_done, 1'b1);
            check_eq("st_ldv", o_ldv, 1'b0);
            check_eq("st_mis", o_mis, 1'b0);
            check_eq("st_reqdrop", o_valid, 1'b0);
            check_eq("st_ldhold", o_ld, last_ld[sel]);
            set_valid(sel, 1'b0);
            return;
        end
        if (abort) begin
            rst = 1'b0;
            set_valid(sel, 1'b0);
            @(negedge clk);
            check_idle_outputs("abort");
            rst = 1'b1;
            set_rsp(sel, 1'b1);
            mem_rsp_rdata = rd;
            @(negedge clk);
            check_eq("stray_done", o_done, 1'b0);
            check_eq("stray_ldv", o_ldv, 1'b0);
            check_eq("stray_ready", o_ready, 1'b1);
            set_rsp(sel, 1'b0);
            last_ld[0] = 64'd0;
            last_ld[1] = 64'd0;
            return;
        end
        for (int r = 0; r <= rdly; r++) begin
            check_eq("rsp_nodone", o_done, 1'b0);
            check_eq("rsp_noreq", o_valid, 1'b0);
            set_rsp(sel, r == rdly);
            mem_rsp_rdata = (r == rdly) ? rd : {$urandom, $urandom};
            @(negedge clk);
        end
        set_rsp(sel, 1'b0);
        check_eq("ld_done", o_done, 1'b1);
        check_eq("ld_valid", o_ldv, 1'b1);
        check_eq("ld_mis", o_mis, 1'b0);
        check_eq("ld_data", o_ld, eld);
        check_eq("ld_tag", o_tag, tg);
        cap_ld = o_ld;
        last_ld[sel] = eld;
        set_valid(sel, 1'b0);
    endtask

    initial begin
        bit          s, st, sg, ab;
        logic [1:0]  sz;
        logic [31:0] ad;

        rst = 1'b0;
        op_valid_a = 1'b0; op_valid_b = 1'b0;
        mem_rsp_valid_a = 1'b0; mem_rsp_valid_b = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_rdata = 64'd0;
        scramble();
        last_ld[0] = 64'd0; last_ld[1] = 64'd0;
        cap_be = 64'd0; cap_wd = 64'd0; cap_ld = 64'd0;
        sel_r = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("rst_a");
        sel_r = 1'b1;
        #1;
        check_idle_outputs("rst_b");
        rst = 1'b1;

        // Directed cases from the unit's documented behaviour.
        run_op(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_1001, 64'hAB, 5'd1, 64'd0, 0, 0, 1'b0);
        check_eq("sb_be", cap_be, 64'h4);
        check_eq("sb_wdata", cap_wd, 64'h00AB_0000);
        run_op(1'b0, 1'b0, 2'd0, 1'b1, 32'h0000_1003, 64'd0, 5'h11, 64'h1234_5680, 0, 3, 1'b0);
        check_eq("lb_data", cap_ld, 64'hFFFF_FF80);
        run_op(1'b0, 1'b0, 2'd1, 1'b0, 32'h0000_1002, 64'd0, 5'h07, 64'h1234_5680, 1, 0, 1'b0);
        check_eq("lhu_data", cap_ld, 64'h5680);
        run_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_1002, 64'd0, 5'h03, 64'h1234_5680, 0, 0, 1'b0);
        run_op(1'b0, 1'b1, 2'd3, 1'b0, 32'h0000_1000, 64'h55, 5'h02, 64'd0, 0, 0, 1'b0);
        run_op(1'b1, 1'b1, 2'd3, 1'b0, 32'h0000_0008, 64'h1122_3344_5566_7788, 5'd0, 64'd0, 0, 0, 1'b0);
        check_eq("sd_be", cap_be, 64'hFF);
        run_op(1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_000C, 64'hCAFE_BABE, 5'd0, 64'd0, 0, 0, 1'b0);
        check_eq("sw_be", cap_be, 64'hF0);
        check_eq("sw_wdata", cap_wd, 64'hCAFE_BABE_0000_0000);
        run_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0015, 64'd0, 5'h1F, 64'h0011_9922_3344_5566, 0, 1, 1'b0);
        check_eq("lb64_data", cap_ld, 64'hFFFF_FFFF_FFFF_FF99);
        run_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_2002, 64'hBEEF, 5'd0, 64'd0, 5, 0, 1'b0);
        run_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h8000_0000, 64'd0, 5'h0A, 64'hDEAD_BEEF, 0, 1, 1'b1);
        run_op(1'b1, 1'b0, 2'd2, 1'b1, 32'h8000_0004, 64'd0, 5'h0B, 64'h8765_4321_0000_0000, 2, 0, 1'b0);

        // Random ops across both units.
        for (int t = 0; t < 250; t++) begin
            s  = 1'($urandom);
            st = 1'($urandom);
            sg = 1'($urandom);
            sz = 2'($urandom);
            ad = {($urandom_range(0, 3) == 0) ? 4'h8 : 4'h1, 28'($urandom)};
            if ($urandom_range(0, 2) != 0) ad[2:0] = 3'd0;
            ab = !st && ($urandom_range(0, 19) == 0);
            run_op(s, st, sz, sg, ad, {$urandom, $urandom}, 5'($urandom),
                   {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3), ab);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
